// File: rtl/ps2_keyboard_tx_if.sv
// Key-event stimulus and PS/2 line/status bundle for ps2_keyboard_tx.
// PS2_TX_PARITY_INJECT_EN adds the inject_err stimulus signal.
interface ps2_keyboard_tx_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             key_action;
  logic [7:0]       scan_code;
  logic             key_release;
  logic             key_extended;
  logic             ps2_clk;
  logic             ps2_dat;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;

`ifdef PS2_TX_PARITY_INJECT_EN
  logic             inject_err;

  modport master (
    output key_action, scan_code, key_release, key_extended, inject_err,
    input  ps2_clk, ps2_dat, busy, fifo_level, overflow
  );

  modport slave (
    input  key_action, scan_code, key_release, key_extended, inject_err,
    output ps2_clk, ps2_dat, busy, fifo_level, overflow
  );
`else
  modport master (
    output key_action, scan_code, key_release, key_extended,
    input  ps2_clk, ps2_dat, busy, fifo_level, overflow
  );

  modport slave (
    input  key_action, scan_code, key_release, key_extended,
    output ps2_clk, ps2_dat, busy, fifo_level, overflow
  );
`endif
endinterface

// File: rtl/ps2_keyboard_tx.sv
// PS/2 keyboard-side transmitter: key events -> E0/F0-prefixed bytes -> FIFO -> 11-bit odd-parity frames.
// Optional PS2_TX_PARITY_INJECT_EN: inject_err sampled in LOAD inverts that frame's parity bit.
module ps2_keyboard_tx #(
  parameter int unsigned CLK_DIV    = 1250,
  parameter int unsigned GAP_CYCLES = 2500,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  ps2_keyboard_tx_if.slave kbd
);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = AW + 1;
  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       STOP_BIT = 4'd10;
  localparam logic [7:0]       PFX_EXT  = 8'hE0;
  localparam logic [7:0]       PFX_BRK  = 8'hF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_bit, w_bit_nxt;
  logic [10:0]      r_frame, w_frame_nxt;
  logic             r_ps2_clk, r_ps2_dat, r_busy, r_overflow;
  logic             w_clk_nxt, w_dat_nxt, w_busy_nxt;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_level, w_level_nxt, w_free, w_need;
  logic [AW-1:0]    w_wa0, w_wa1, w_wa2;
  logic [7:0]       w_b0, w_b1, w_b2, w_head;
  logic             w_push, w_drop, w_pop, w_have;
  logic             w_par, w_inject, w_last_div, w_last_gap;

`ifdef PS2_TX_PARITY_INJECT_EN
  assign w_inject = kbd.inject_err;
`else
  assign w_inject = 1'b0;
`endif

  // ---------------- event -> byte FIFO ----------------
  assign w_need = LVL_W'(1) + LVL_W'(kbd.key_extended) + LVL_W'(kbd.key_release);
  assign w_free = LVL_W'(FIFO_DEPTH) - r_level;
  assign w_push = kbd.key_action && (w_need <= w_free);
  assign w_drop = kbd.key_action && !(w_need <= w_free);
  assign w_pop  = (r_state == S_LOAD);

  assign w_wa0  = r_wr_ptr[AW-1:0];
  assign w_wa1  = w_wa0 + AW'(1);
  assign w_wa2  = w_wa0 + AW'(2);
  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  assign w_level_nxt = r_level + (w_push ? w_need : '0) - (w_pop ? LVL_W'(1) : '0);

  always_comb begin
    w_b0 = kbd.scan_code;
    w_b1 = kbd.scan_code;
    w_b2 = kbd.scan_code;
    case ({kbd.key_extended, kbd.key_release})
      2'b01: w_b0 = PFX_BRK;
      2'b10: w_b0 = PFX_EXT;
      2'b11: begin
        w_b0 = PFX_EXT;
        w_b1 = PFX_BRK;
      end
      default: ;
    endcase
  end

  // The whole event lands in one cycle so prefixes can never be split from their code.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[w_wa0] <= w_b0;
      if (w_need > LVL_W'(1)) r_mem[w_wa1] <= w_b1;
      if (w_need > LVL_W'(2)) r_mem[w_wa2] <= w_b2;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + w_need;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
      r_level <= w_level_nxt;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // ---------------- frame FSM ----------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_frame   <= '1;
      r_ps2_clk <= 1'b1;
      r_ps2_dat <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_frame   <= w_frame_nxt;
      r_ps2_clk <= w_clk_nxt;
      r_ps2_dat <= w_dat_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign w_last_div = (r_cnt == DIV_LAST);
  assign w_last_gap = (r_cnt == GAP_LAST);
  // A push in the current cycle also wakes IDLE, giving LOAD one cycle after the strobe.
  assign w_have     = (r_level != '0) || w_push;
  assign w_par      = ~(^w_head) ^ w_inject;

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_frame_nxt = r_frame;
    case (r_state)
      S_IDLE: if (w_have) w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_state_nxt = S_HIGH;
        w_bit_nxt   = '0;
        w_frame_nxt = {1'b1, w_par, w_head, 1'b0};
      end
      S_HIGH: if (w_last_div) w_state_nxt = S_LOW;
      S_LOW: begin
        if (w_last_div) begin
          w_state_nxt = (r_bit == STOP_BIT) ? S_GAP : S_HIGH;
          w_bit_nxt   = r_bit + 4'd1;
          w_frame_nxt = {1'b1, r_frame[10:1]};
        end
      end
      S_GAP: if (w_last_gap) w_state_nxt = w_have ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if ((w_state_nxt != r_state) || (r_state == S_IDLE)) w_cnt_nxt = '0;
    else                                                  w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  // Data changes only when a high phase begins; it then holds through the low phase.
  always_comb begin
    w_clk_nxt  = (w_state_nxt != S_LOW);
    w_dat_nxt  = 1'b1;
    if ((w_state_nxt == S_HIGH) || (w_state_nxt == S_LOW)) w_dat_nxt = w_frame_nxt[0];
    w_busy_nxt = (w_state_nxt != S_IDLE) || (w_level_nxt != '0);
  end

  assign kbd.ps2_clk    = r_ps2_clk;
  assign kbd.ps2_dat    = r_ps2_dat;
  assign kbd.busy       = r_busy;
  assign kbd.fifo_level = r_level;
  assign kbd.overflow   = r_overflow;
endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Bench for ps2_keyboard_tx (CLK_DIV=4, GAP_CYCLES=8, FIFO_DEPTH=8): vector table, corner sequences, random bursts.
// Optional PS2_TX_PARITY_INJECT_EN enables the parity-inject sequence.
module tb_ps2_keyboard_tx;
  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYCLES = 8;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int FRAME_CYC  = 22 * CLK_DIV;
  localparam int SPACING    = 2 * CLK_DIV + GAP_CYCLES + 1;
  localparam int PER_FRAME  = FRAME_CYC + GAP_CYCLES + 20;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ps2_keyboard_tx_if #(.FIFO_DEPTH(FIFO_DEPTH)) kbd ();

  ps2_keyboard_tx #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .kbd     (kbd)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  int t_evt = 0;

  // ---------------- line monitor ----------------
  typedef struct {
    logic [10:0] bits;
    int          first_fall;
    int          last_fall;
  } frame_t;

  frame_t      frames[$];
  int          fall_count = 0;
  int          nbit = 0;
  int          cur_first = 0;
  logic [10:0] cur = '0;
  logic        prev_clk = 1'b1;

  always @(negedge clk) begin
    if (!resetn) begin
      nbit     = 0;
      prev_clk = 1'b1;
    end else begin
      if (prev_clk && !kbd.ps2_clk) begin
        fall_count++;
        if (nbit == 0) cur_first = cyc;
        cur[nbit] = kbd.ps2_dat;
        nbit++;
        if (nbit == 11) begin
          frames.push_back('{bits: cur, first_fall: cur_first, last_fall: cyc});
          nbit = 0;
        end
      end
      prev_clk = kbd.ps2_clk;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic send_event(input logic ext, input logic rel, input logic [7:0] code);
    kbd.key_extended = ext;
    kbd.key_release  = rel;
    kbd.scan_code    = code;
    kbd.key_action   = 1'b1;
    t_evt = cyc;
    @(negedge clk);
    kbd.key_action   = 1'b0;
  endtask

  task automatic check_byte(input string name, input int idx, input logic [7:0] d, input logic p);
    frame_t f;
    n_total++;
    if (idx >= frames.size()) begin
      $display("FAIL %s[%0d]: frame missing, got %0d frames, required data %h", name, idx, frames.size(), d);
      return;
    end
    f = frames[idx];
    if (f.bits[8:1] == d && f.bits[9] == p && f.bits[0] == 1'b0 && f.bits[10] == 1'b1) n_pass++;
    else $display("FAIL %s[%0d]: got frame %b, required data %h parity %0d start 0 stop 1",
                  name, idx, f.bits, d, p);
  endtask

  task automatic check_spacing(input string name, input int idx);
    int act;
    act = -1;
    if (idx < frames.size() && idx > 0) act = frames[idx].first_fall - frames[idx-1].last_fall;
    check(name, act, SPACING);
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (frames.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, frames.size(), n);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (kbd.busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, int'(kbd.busy), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ext;
    logic       rel;
    logic [7:0] code;
    int         nb;
    logic [7:0] b [3];
    logic       p [3];
  } vec_t;

  vec_t vecs [6];

  task automatic set_vec(input int i, input logic e, input logic r, input logic [7:0] c, input int nb,
                         input logic [7:0] b0, input logic p0, input logic [7:0] b1, input logic p1,
                         input logic [7:0] b2, input logic p2);
    vecs[i].ext  = e;
    vecs[i].rel  = r;
    vecs[i].code = c;
    vecs[i].nb   = nb;
    vecs[i].b[0] = b0; vecs[i].p[0] = p0;
    vecs[i].b[1] = b1; vecs[i].p[1] = p1;
    vecs[i].b[2] = b2; vecs[i].p[2] = p2;
  endtask

  logic [7:0]  exp_q[$];
  logic [10:0] exp_bits;
  int          remain, need, t0, fc, nev;
  logic        r_ext, r_rel;
  logic [7:0]  r_code;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d checks", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    set_vec(0, 1'b1, 1'b1, 8'h75, 3, 8'hE0, 1'b0, 8'hF0, 1'b1, 8'h75, 1'b0);
    set_vec(1, 1'b1, 1'b0, 8'h6B, 2, 8'hE0, 1'b0, 8'h6B, 1'b0, 8'h00, 1'b0);
    set_vec(2, 1'b0, 1'b1, 8'h5A, 2, 8'hF0, 1'b1, 8'h5A, 1'b1, 8'h00, 1'b0);
    set_vec(3, 1'b0, 1'b0, 8'hFF, 1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    set_vec(4, 1'b0, 1'b0, 8'h00, 1, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    set_vec(5, 1'b0, 1'b0, 8'h80, 1, 8'h80, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    kbd.key_action   = 1'b0;
    kbd.key_extended = 1'b0;
    kbd.key_release  = 1'b0;
    kbd.scan_code    = 8'h00;
`ifdef PS2_TX_PARITY_INJECT_EN
    kbd.inject_err   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_clk", int'(kbd.ps2_clk), 1);
    check("rst_dat", int'(kbd.ps2_dat), 1);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(kbd.busy), 0);
    check("rst_level", int'(kbd.fifo_level), 0);
    check("rst_ovf", int'(kbd.overflow), 0);

    // ---- make 0x1C: latency, bit pattern, busy fall ----
    frames.delete();
    t0 = cyc;
    send_event(1'b0, 1'b0, 8'h1C);
    check("t1_level_c1", int'(kbd.fifo_level), 1);
    check("t1_busy_c1", int'(kbd.busy), 1);
    check("t1_dat_c1", int'(kbd.ps2_dat), 1);
    @(negedge clk);
    check("t1_start_dat_c2", int'(kbd.ps2_dat), 0);
    check("t1_clk_c2", int'(kbd.ps2_clk), 1);
    check("t1_level_c2", int'(kbd.fifo_level), 0);
    repeat (FRAME_CYC + GAP_CYCLES - 1) @(negedge clk);
    check("t1_busy_last_gap", int'(kbd.busy), 1);
    @(negedge clk);
    check("t1_busy_after_gap", int'(kbd.busy), 0);
    check("t1_frames", frames.size(), 1);
    if (frames.size() > 0) begin
      exp_bits = 11'b10000111000;
      check("t1_bits", int'(frames[0].bits), int'(exp_bits));
      check("t1_first_fall", frames[0].first_fall - t0, 2 + CLK_DIV);
    end else begin
      check("t1_bits", -1, 0);
    end

    // ---- table: prefixing, parity, inter-frame spacing ----
    for (int i = 0; i < 6; i++) begin
      frames.delete();
      send_event(vecs[i].ext, vecs[i].rel, vecs[i].code);
      check($sformatf("vec%0d_level", i), int'(kbd.fifo_level), vecs[i].nb);
      wait_frames($sformatf("vec%0d_nframes", i), vecs[i].nb, vecs[i].nb * PER_FRAME);
      for (int j = 0; j < vecs[i].nb; j++) begin
        check_byte($sformatf("vec%0d_byte", i), j, vecs[i].b[j], vecs[i].p[j]);
        if (j > 0) check_spacing($sformatf("vec%0d_gap%0d", i, j), j);
      end
      wait_idle($sformatf("vec%0d_idle", i), 2 * PER_FRAME);
    end

    // ---- overflow: four 3-byte events while a frame is in flight ----
    frames.delete();
    send_event(1'b0, 1'b0, 8'h1C);
    repeat (4) @(negedge clk);
    send_event(1'b1, 1'b1, 8'h11);
    check("t3_level_e1", int'(kbd.fifo_level), 3);
    check("t3_ovf_e1", int'(kbd.overflow), 0);
    send_event(1'b1, 1'b1, 8'h22);
    check("t3_level_e2", int'(kbd.fifo_level), 6);
    check("t3_ovf_e2", int'(kbd.overflow), 0);
    send_event(1'b1, 1'b1, 8'h33);
    check("t3_level_e3", int'(kbd.fifo_level), 6);
    check("t3_ovf_e3", int'(kbd.overflow), 1);
    send_event(1'b1, 1'b1, 8'h44);
    check("t3_level_e4", int'(kbd.fifo_level), 6);
    wait_frames("t3_nframes", 7, 7 * PER_FRAME);
    exp_q = '{8'h1C, 8'hE0, 8'hF0, 8'h11, 8'hE0, 8'hF0, 8'h22};
    foreach (exp_q[k]) check_byte("t3_byte", k, exp_q[k], ($countones(exp_q[k]) % 2) == 0);
    wait_idle("t3_idle", 2 * PER_FRAME);
    check("t3_nframes_final", frames.size(), 7);
    check("t3_ovf_sticky", int'(kbd.overflow), 1);

    // ---- strobe during frame, push and pop in the same cycle ----
    frames.delete();
    send_event(1'b0, 1'b0, 8'h16);
    check("t4_level_a", int'(kbd.fifo_level), 1);
    send_event(1'b0, 1'b0, 8'h1E);
    check("t4_level_pushpop", int'(kbd.fifo_level), 1);
    repeat (20) @(negedge clk);
    send_event(1'b0, 1'b0, 8'h26);
    check("t4_level_mid", int'(kbd.fifo_level), 2);
    wait_frames("t4_nframes", 3, 3 * PER_FRAME);
    check_byte("t4_byte", 0, 8'h16, 1'b0);
    check_byte("t4_byte", 1, 8'h1E, 1'b1);
    check_byte("t4_byte", 2, 8'h26, 1'b0);
    check_spacing("t4_gap1", 1);
    check_spacing("t4_gap2", 2);
    wait_idle("t4_idle", 2 * PER_FRAME);

    // ---- async reset during bit 5 ----
    frames.delete();
    fc = fall_count;
    send_event(1'b1, 1'b0, 8'h5A);
    repeat (2 + 10 * CLK_DIV + CLK_DIV - 1) @(negedge clk);
    #1;
    check("t5_in_low", int'(kbd.ps2_clk), 0);
    check("t5_falls_before", fall_count - fc, 6);
    #1 resetn = 1'b0;
    #1;
    check("t5_clk", int'(kbd.ps2_clk), 1);
    check("t5_dat", int'(kbd.ps2_dat), 1);
    check("t5_level", int'(kbd.fifo_level), 0);
    check("t5_busy", int'(kbd.busy), 0);
    check("t5_ovf_cleared", int'(kbd.overflow), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    fc = fall_count;
    repeat (3 * PER_FRAME) @(negedge clk);
    check("t5_no_edges", fall_count - fc, 0);
    check("t5_no_frames", frames.size(), 0);
    check("t5_busy_after", int'(kbd.busy), 0);

`ifdef PS2_TX_PARITY_INJECT_EN
    // ---- parity inject for one frame only ----
    frames.delete();
    kbd.inject_err = 1'b1;
    send_event(1'b0, 1'b0, 8'h1C);
    repeat (3) @(negedge clk);
    kbd.inject_err = 1'b0;
    send_event(1'b0, 1'b0, 8'h1C);
    wait_frames("t6_nframes", 2, 2 * PER_FRAME);
    check_byte("t6_injected", 0, 8'h1C, 1'b1);
    check_byte("t6_clean", 1, 8'h1C, 1'b0);
    wait_idle("t6_idle", 2 * PER_FRAME);
`endif

    // ---- random bursts against a byte-queue model ----
    for (int b = 0; b < 6; b++) begin
      frames.delete();
      exp_q.delete();
      remain = FIFO_DEPTH;
      nev = 0;
      while (nev < 8) begin
        r_ext  = 1'($urandom_range(0, 1));
        r_rel  = 1'($urandom_range(0, 1));
        r_code = 8'($urandom_range(0, 255));
        need   = 1 + int'(r_ext) + int'(r_rel);
        if (need > remain) break;
        send_event(r_ext, r_rel, r_code);
        if (r_ext) exp_q.push_back(8'hE0);
        if (r_rel) exp_q.push_back(8'hF0);
        exp_q.push_back(r_code);
        remain -= need;
        nev++;
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      wait_frames($sformatf("rnd%0d_nframes", b), exp_q.size(), exp_q.size() * PER_FRAME + 100);
      foreach (exp_q[k]) check_byte($sformatf("rnd%0d_byte", b), k, exp_q[k], ($countones(exp_q[k]) % 2) == 0);
      wait_idle($sformatf("rnd%0d_idle", b), 2 * PER_FRAME);
      check($sformatf("rnd%0d_level", b), int'(kbd.fifo_level), 0);
      check($sformatf("rnd%0d_ovf", b), int'(kbd.overflow), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
